// File: rtl/bram_multichan_dma.sv
// BRAM-to-register DMA: fills the back bank of a ping-pong sample store with NUM_CH x NUM_WORDS
// words read from shared BRAM, then swaps banks so readers always see a complete, stable set.
module bram_multichan_dma #(
  parameter int NUM_CH      = 2,
  parameter int NUM_WORDS   = 32,
  parameter int SAMPLE_W    = 16,
  parameter int BRAM_LAT    = 2,
  parameter int ADDR_STRIDE = 4,
  parameter int CH_STRIDE   = 128,
  parameter int AUTO_RELOAD = 0,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic [31:0]         BRAM_addr,
  output logic                BRAM_clk,
  output logic [31:0]         BRAM_din,
  input  logic [31:0]         BRAM_dout,
  output logic                BRAM_en,
  output logic                BRAM_rst,
  output logic [3:0]          BRAM_we,
  input  logic [31:0]         base_addr,
  input  logic                start,
  input  logic                clr_err,
  input  logic [CW-1:0]       rd_ch,
  input  logic [WW-1:0]       rd_idx,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                busy,
  output logic                done,
  output logic                active_bank,
  output logic                overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_SWAP} state_t;
  typedef struct packed {
    logic [CW-1:0] ch;
    logic [WW-1:0] idx;
    logic          last;
  } tag_t;

  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
  localparam logic [WW-1:0] LAST_IDX = WW'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [31:0]         base_q, base_d, addr_q, addr_d;
  logic [CW-1:0]       ch_q, ch_d, nxt_ch, issue_ch;
  logic [WW-1:0]       idx_q, idx_d, nxt_idx, issue_idx;
  logic [31:0]         issue_base;
  logic                issue;
  logic                en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic                bank_q, bank_d, ovr_q, ovr_d, brst_q;
  logic [SAMPLE_W-1:0] rd_data_q, rd_data_d;
  logic [BRAM_LAT:0]   vld_pipe_q, vld_pipe_d;
  tag_t                tag_pipe_q [BRAM_LAT+1];
  tag_t                tag_pipe_d [BRAM_LAT+1];
  logic [SAMPLE_W-1:0] buf_mem [2][NUM_CH][NUM_WORDS];
  logic [31:0]         unused_dout;

  assign unused_dout = BRAM_dout;

  always_comb begin
    state_d = state_q; base_d = base_q; addr_d = addr_q;
    ch_d = ch_q; idx_d = idx_q;
    en_d = 1'b0; busy_d = busy_q; done_d = 1'b0; bank_d = bank_q;
    issue = 1'b0; issue_base = base_q; issue_ch = '0; issue_idx = '0;
    nxt_ch = ch_q; nxt_idx = idx_q + 1'b1;
    if (idx_q == LAST_IDX) begin
      nxt_ch  = ch_q + 1'b1;
      nxt_idx = '0;
    end
    case (state_q)
      S_IDLE: if (start) begin
        issue = 1'b1; issue_base = base_addr; base_d = base_addr;
        state_d = S_ISSUE; busy_d = 1'b1;
      end
      S_ISSUE: begin
        if (ch_q == LAST_CH && idx_q == LAST_IDX) state_d = S_DRAIN;
        else begin
          issue = 1'b1; issue_ch = nxt_ch; issue_idx = nxt_idx;
        end
      end
      // the swap waits for the last tag so the back bank is complete when it turns front
      S_DRAIN: if (vld_pipe_q[BRAM_LAT] && tag_pipe_q[BRAM_LAT].last) begin
        state_d = S_SWAP; done_d = 1'b1; bank_d = ~bank_q;
      end
      S_SWAP: begin
        if (AUTO_RELOAD != 0) begin
          issue = 1'b1; issue_base = base_addr; base_d = base_addr; state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE; busy_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      en_d  = 1'b1; ch_d = issue_ch; idx_d = issue_idx;
      addr_d = issue_base + 32'(issue_ch) * 32'(CH_STRIDE) + 32'(issue_idx) * 32'(ADDR_STRIDE);
    end
    vld_pipe_d = {vld_pipe_q[BRAM_LAT-1:0], issue};
    tag_pipe_d[0] = tag_t'{ch: issue_ch, idx: issue_idx,
                           last: (issue_ch == LAST_CH && issue_idx == LAST_IDX)};
    for (int i = 1; i <= BRAM_LAT; i++) tag_pipe_d[i] = tag_pipe_q[i-1];
    ovr_d = ovr_q;
    if (start && busy_q && AUTO_RELOAD == 0) ovr_d = 1'b1;
    else if (clr_err)                       ovr_d = 1'b0;
    rd_data_d = '0;
    if (int'(rd_ch) < NUM_CH && int'(rd_idx) < NUM_WORDS) rd_data_d = buf_mem[bank_q][rd_ch][rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; base_q <= '0; addr_q <= '0; ch_q <= '0; idx_q <= '0;
      en_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; bank_q <= 1'b0; ovr_q <= 1'b0;
      brst_q <= 1'b1; rd_data_q <= '0; vld_pipe_q <= '0;
    end else begin
      state_q <= state_d; base_q <= base_d; addr_q <= addr_d; ch_q <= ch_d; idx_q <= idx_d;
      en_q <= en_d; busy_q <= busy_d; done_q <= done_d; bank_q <= bank_d; ovr_q <= ovr_d;
      brst_q <= 1'b0; rd_data_q <= rd_data_d; vld_pipe_q <= vld_pipe_d;
    end
  end

  // tags only matter alongside their valid bit, so they carry no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i <= BRAM_LAT; i++) tag_pipe_q[i] <= tag_pipe_d[i];
  end

  always_ff @(posedge clk) begin
    if (!rst && vld_pipe_q[BRAM_LAT])
      buf_mem[~bank_q][tag_pipe_q[BRAM_LAT].ch][tag_pipe_q[BRAM_LAT].idx] <= BRAM_dout[SAMPLE_W-1:0];
  end

  assign BRAM_addr   = addr_q;
  assign BRAM_clk    = clk;
  assign BRAM_din    = '0;
  assign BRAM_en     = en_q;
  assign BRAM_rst    = brst_q;
  assign BRAM_we     = '0;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign active_bank = bank_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_bram_multichan_dma.sv
// Directed bench for bram_multichan_dma: one-shot instance and an auto-reload instance, each with
// a BRAM latency model, checked every cycle against a fill/bank model plus literal expectations.
module tb_bram_multichan_dma;
  localparam int N = 8, LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start0 = 1'b0, start1 = 1'b0, clr_err = 1'b0;
  logic [31:0] base0 = '0, base1 = '0, xor0 = '0, xor1 = '0;
  logic rd_ch = 1'b0;
  logic [1:0] rd_idx = '0;

  logic [31:0] a0, din0, dout0, a1, din1, dout1;
  logic en0, bclk0, brst0, busy0, done0, bank0, ovr0;
  logic en1, bclk1, brst1, busy1, done1, bank1, ovr1;
  logic [3:0] we0, we1;
  logic [15:0] rdd0, rdd1;

  bram_multichan_dma #(.NUM_CH(2), .NUM_WORDS(4), .SAMPLE_W(16), .BRAM_LAT(LAT), .ADDR_STRIDE(4),
    .CH_STRIDE(128), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .rst(rst), .BRAM_addr(a0), .BRAM_clk(bclk0), .BRAM_din(din0), .BRAM_dout(dout0),
    .BRAM_en(en0), .BRAM_rst(brst0), .BRAM_we(we0), .base_addr(base0), .start(start0),
    .clr_err(clr_err), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_data(rdd0), .busy(busy0),
    .done(done0), .active_bank(bank0), .overrun(ovr0));

  bram_multichan_dma #(.NUM_CH(2), .NUM_WORDS(4), .SAMPLE_W(16), .BRAM_LAT(LAT), .ADDR_STRIDE(4),
    .CH_STRIDE(128), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .rst(rst), .BRAM_addr(a1), .BRAM_clk(bclk1), .BRAM_din(din1), .BRAM_dout(dout1),
    .BRAM_en(en1), .BRAM_rst(brst1), .BRAM_we(we1), .base_addr(base1), .start(start1),
    .clr_err(clr_err), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_data(rdd1), .busy(busy1),
    .done(done1), .active_bank(bank1), .overrun(ovr1));

  // BRAM: word at byte address a holds a ^ xorN, valid LAT cycles after the address
  logic [31:0] bq0 [LAT], bq1 [LAT];
  always @(posedge clk) begin
    if (en0) bq0[0] <= a0 ^ xor0;
    if (en1) bq1[0] <= a1 ^ xor1;
    for (int i = 1; i < LAT; i++) begin
      bq0[i] <= bq0[i-1];
      bq1[i] <= bq1[i-1];
    end
  end
  assign dout0 = bq0[LAT-1];
  assign dout1 = bq1[LAT-1];

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          live = 1'b0;
  bit          m_busy [2], m_bank [2];
  int          m_j [2];
  logic [31:0] m_base [2], m_x [2];
  logic [15:0] m_mem [2][2][2][4];
  bit          m_val [2][2];
  logic [31:0] e_addr [2];
  logic        e_en [2], e_busy [2], e_done [2], e_bank [2], e_ovr [2], e_brst [2], e_rdk [2];
  logic [15:0] e_rd [2];

  function automatic logic [15:0] smp(input logic [31:0] b, input logic [31:0] x, input int c,
                                      input int w);
    logic [31:0] a;
    a = b + 32'(c) * 32'd128 + 32'(w) * 32'd4;
    return a[15:0] ^ x[15:0];
  endfunction

  task automatic model_step(input int d);
    logic st;
    logic [31:0] bi, xi;
    st = (d == 0) ? start0 : start1;
    bi = (d == 0) ? base0 : base1;
    xi = (d == 0) ? xor0 : xor1;
    if (rst) begin
      if (m_busy[d]) m_val[d][m_bank[d] ^ 1'b1] = 1'b0;
      m_busy[d] = 0; m_j[d] = 0; m_bank[d] = 0;
      e_en[d] = 0; e_addr[d] = 0; e_done[d] = 0; e_busy[d] = 0; e_bank[d] = 0;
      e_ovr[d] = 0; e_rd[d] = 0; e_rdk[d] = 1; e_brst[d] = 1;
    end else begin
      e_brst[d] = 0;
      e_rdk[d] = m_val[d][m_bank[d]];
      e_rd[d]  = m_mem[d][m_bank[d]][rd_ch][rd_idx];
      if (st && m_busy[d] && d == 0) e_ovr[d] = 1;
      else if (clr_err)              e_ovr[d] = 0;
      if (m_busy[d]) begin
        m_j[d]++;
        if (m_j[d] == N + LAT + 2) begin
          if (d == 1) begin
            m_j[d] = 1; m_base[d] = bi; m_x[d] = xi;
          end else begin
            m_busy[d] = 0; m_j[d] = 0;
          end
        end
      end else if (st) begin
        m_busy[d] = 1; m_j[d] = 1; m_base[d] = bi; m_x[d] = xi;
      end
      e_busy[d] = m_busy[d];
      e_en[d]   = m_busy[d] && m_j[d] >= 1 && m_j[d] <= N;
      if (e_en[d]) e_addr[d] = m_base[d] + 32'((m_j[d] - 1) / 4) * 32'd128 + 32'((m_j[d] - 1) % 4) * 32'd4;
      e_done[d] = m_busy[d] && m_j[d] == N + LAT + 1;
      if (e_done[d]) begin
        for (int c = 0; c < 2; c++)
          for (int w = 0; w < 4; w++)
            m_mem[d][m_bank[d] ^ 1'b1][c][w] = smp(m_base[d], m_x[d], c, w);
        m_val[d][m_bank[d] ^ 1'b1] = 1'b1;
        m_bank[d] = ~m_bank[d];
      end
      e_bank[d] = m_bank[d];
    end
  endtask

  always @(posedge clk) begin
    live = 1'b1;
    model_step(0);
    model_step(1);
  end

  task automatic cmp(input int d, input logic [31:0] a, input logic en, input logic brst,
                     input logic [15:0] rd, input logic b, input logic dn, input logic ab,
                     input logic ov);
    chk($sformatf("m%0d_addr", d), a, e_addr[d]);
    chk($sformatf("m%0d_en", d), 32'(en), 32'(e_en[d]));
    chk($sformatf("m%0d_brst", d), 32'(brst), 32'(e_brst[d]));
    chk($sformatf("m%0d_busy", d), 32'(b), 32'(e_busy[d]));
    chk($sformatf("m%0d_done", d), 32'(dn), 32'(e_done[d]));
    chk($sformatf("m%0d_bank", d), 32'(ab), 32'(e_bank[d]));
    chk($sformatf("m%0d_ovr", d), 32'(ov), 32'(e_ovr[d]));
    if (e_rdk[d]) chk($sformatf("m%0d_rd", d), 32'(rd), 32'(e_rd[d]));
  endtask

  always @(negedge clk) begin
    if (live) begin
      cmp(0, a0, en0, brst0, rdd0, busy0, done0, bank0, ovr0);
      cmp(1, a1, en1, brst1, rdd1, busy1, done1, bank1, ovr1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic pulse1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  logic [31:0] t2_addr [8];
  logic [31:0] t6_addr [8];

  initial begin
    t2_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h180, 32'h184, 32'h188, 32'h18C};
    t6_addr = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h78, 32'h7C, 32'h80, 32'h84};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_addr", a0, 32'h0);
    chk("rst_en", 32'(en0), 32'h0);
    chk("rst_we", 32'(we0), 32'h0);
    chk("rst_din", din0, 32'h0);
    chk("rst_rd", 32'(rdd0), 32'h0);
    chk("rst_busy_done", {busy0, done0, bank0, ovr0}, 32'h0);
    chk("rst_brst_hi", 32'(brst0), 32'h1);
    rst = 1'b0;
    chk("rst_brst_hold", 32'(brst0), 32'h1);
    @(negedge clk);
    chk("rst_brst_drop", 32'(brst0), 32'h0);

    // basic fill, BRAM word = address
    base0 = 32'h100; rd_ch = 1'b1; rd_idx = 2'd2;
    pulse0();
    for (int j = 1; j <= 12; j++) begin
      if (j <= 8) chk($sformatf("t2_addr%0d", j), a0, t2_addr[j-1]);
      if (j == 1 || j == 8) chk("t2_en", 32'(en0), 32'h1);
      if (j == 9) chk("t2_en_off", 32'(en0), 32'h0);
      if (j == 10 || j == 11) chk("t2_done", 32'(done0), 32'(j == 11));
      if (j == 11) chk("t2_busy_swap", 32'(busy0), 32'h1);
      if (j == 12) chk("t2_rd", 32'(rdd0), 32'h0188);
      @(negedge clk);
    end

    // ping-pong: front bank stable until the cycle after done
    xor0 = 32'h5000;
    pulse0();
    for (int j = 1; j <= 12; j++) begin
      if (j == 5 || j == 11) chk("t3_rd_old", 32'(rdd0), 32'h0188);
      if (j == 10) chk("t3_bank_before", 32'(bank0), 32'h1);
      if (j == 11) chk("t3_bank_after", 32'(bank0), 32'h0);
      if (j == 12) chk("t3_rd_new", 32'(rdd0), 32'h5188);
      @(negedge clk);
    end

    // overrun: start while busy, set beats clear, then clear alone
    xor0 = 32'h0A00;
    pulse0();
    for (int j = 1; j <= 13; j++) begin
      if (j == 3 || j == 5) chk("t4_ovr_set", 32'(ovr0), 32'h1);
      if (j == 7) chk("t4_ovr_clr", 32'(ovr0), 32'h0);
      if (j == 11) chk("t4_done", 32'(done0), 32'h1);
      if (j == 12) chk("t4_idle", 32'(busy0), 32'h0);
      rd_idx = 2'(j); rd_ch = 1'(j >> 2);
      start0  = (j == 2 || j == 4);
      clr_err = (j == 4 || j == 6);
      @(negedge clk);
    end
    rd_ch = 1'b1; rd_idx = 2'd2;

    // mid-fill reset aborts, then a fresh fill completes
    xor0 = 32'h0C00;
    pulse0();
    for (int j = 1; j <= 14; j++) begin
      if (j == 4) begin
        chk("t5_en", 32'(en0), 32'h0);
        chk("t5_bank", 32'(bank0), 32'h0);
        chk("t5_busy", 32'(busy0), 32'h0);
      end
      if (j == 11) chk("t5_no_done", 32'(done0), 32'h0);
      rst = (j == 3);
      @(negedge clk);
    end
    xor0 = 32'h3000;
    pulse0();
    for (int j = 1; j <= 12; j++) begin
      if (j == 11) chk("t5_done", 32'(done0), 32'h1);
      if (j == 12) begin
        chk("t5_rd", 32'(rdd0), 32'h3188);
        chk("t5_bank1", 32'(bank0), 32'h1);
      end
      @(negedge clk);
    end

    // auto-reload with address wrap; base change mid-fill only affects the next fill
    base1 = 32'hFFFFFFF8;
    pulse1();
    for (int j = 1; j <= 34; j++) begin
      if (j <= 8) chk($sformatf("t6_addr%0d", j), a1, t6_addr[j-1]);
      chk($sformatf("t6_done%0d", j), 32'(done1), 32'(j % 11 == 0));
      if (j == 7) chk("t6_no_ovr", 32'(ovr1), 32'h0);
      if (j == 12) begin
        chk("t6_reload_addr", a1, 32'h1000);
        chk("t6_rd", 32'(rdd1), 32'h0080);
      end
      if (j == 2) base1 = 32'h1000;
      start1 = (j == 5);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
